// File: rtl/dtm_tap_dmi.sv
// JTAG debug transport module: 1149.1 TAP with IDCODE/DTMCS/DMI/BYPASS data registers and a DMI request port.
// Optional dmihardreset support is compiled in with `define DTM_DMIHARDRESET_EN.
module dtm_tap_dmi #(
  parameter int          ABITS      = 7,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001,
  parameter logic [2:0]  IDLE_HINT  = 3'd1
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_op,
  output logic             dmi_hardreset
);

  localparam int DRW = ABITS + 34;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e       r_state;
  tap_state_e       w_state_nxt;
  logic [4:0]       r_ir;
  logic [DRW-1:0]   r_shift;
  logic [DRW-1:0]   w_shift_nxt;
  logic             r_tdo;
  logic             r_req_valid;
  logic [ABITS-1:0] r_req_addr;
  logic [31:0]      r_req_data;
  logic [1:0]       r_req_op;
  logic             r_pending;
  logic [1:0]       r_dmistat;
  logic [31:0]      r_resp_data;
  logic [ABITS-1:0] r_last_addr;

  logic [31:0]      w_dtmcs;
  logic [1:0]       w_op_field;
  logic [1:0]       w_dmi_op;
  logic [31:0]      w_dmi_data;
  logic [ABITS-1:0] w_dmi_addr;
  logic             w_dmi_cap;
  logic             w_dmi_upd;
  logic             w_dtmcs_upd;
  logic             w_issue;
  logic             w_resp_acc;
  logic             w_hardreset_req;
  logic             w_dmireset;

  assign w_dtmcs    = {14'b0, 2'b0, 1'b0, IDLE_HINT, r_dmistat, 6'(ABITS), 4'd1};
  assign w_op_field = r_pending ? 2'd3 : r_dmistat;
  assign w_dmi_op   = r_shift[1:0];
  assign w_dmi_data = r_shift[33:2];
  assign w_dmi_addr = r_shift[DRW-1:34];

  assign w_dmi_cap   = (r_state == CAP_DR) && (r_ir == IR_DMI);
  assign w_dmi_upd   = (r_state == UPD_DR) && (r_ir == IR_DMI);
  assign w_dtmcs_upd = (r_state == UPD_DR) && (r_ir == IR_DTMCS);
  assign w_issue     = w_dmi_upd && !r_pending && (r_dmistat == 2'd0) &&
                       ((w_dmi_op == 2'd1) || (w_dmi_op == 2'd2));
  assign w_resp_acc  = dmi_resp_valid && dmi_resp_ready;

`ifdef DTM_DMIHARDRESET_EN
  assign w_hardreset_req = w_dtmcs_upd && r_shift[17];
`else
  assign w_hardreset_req = 1'b0;
`endif
  assign w_dmireset = w_dtmcs_upd && (r_shift[16] || w_hardreset_req);

  assign TDO            = r_tdo;
  assign dmi_req_valid  = r_req_valid;
  assign dmi_req_addr   = r_req_addr;
  assign dmi_req_data   = r_req_data;
  assign dmi_req_op     = r_req_op;
  assign dmi_resp_ready = r_pending && !r_req_valid;

  // TAP state register
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_state <= TLR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // TAP next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TLR:     w_state_nxt = TMS ? TLR    : RTI;
      RTI:     w_state_nxt = TMS ? SEL_DR : RTI;
      SEL_DR:  w_state_nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  w_state_nxt = TMS ? EX1_DR : SH_DR;
      SH_DR:   w_state_nxt = TMS ? EX1_DR : SH_DR;
      EX1_DR:  w_state_nxt = TMS ? UPD_DR : PA_DR;
      PA_DR:   w_state_nxt = TMS ? EX2_DR : PA_DR;
      EX2_DR:  w_state_nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR:  w_state_nxt = TMS ? SEL_DR : RTI;
      SEL_IR:  w_state_nxt = TMS ? TLR    : CAP_IR;
      CAP_IR:  w_state_nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:   w_state_nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR:  w_state_nxt = TMS ? UPD_IR : PA_IR;
      PA_IR:   w_state_nxt = TMS ? EX2_IR : PA_IR;
      EX2_IR:  w_state_nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR:  w_state_nxt = TMS ? SEL_DR : RTI;
      default: w_state_nxt = TLR;
    endcase
  end

  // Shared IR/DR shift register: capture values and LSB-first shifting with TDI at the selected MSB
  always_comb begin
    w_shift_nxt = r_shift;
    if (r_state == CAP_IR) begin
      w_shift_nxt = {{(DRW-5){1'b0}}, 5'b00001};
    end else if (r_state == SH_IR) begin
      w_shift_nxt = {{(DRW-5){1'b0}}, TDI, r_shift[4:1]};
    end else if (r_state == CAP_DR) begin
      case (r_ir)
        IR_IDCODE: w_shift_nxt = {{(DRW-32){1'b0}}, IDCODE_VAL};
        IR_DTMCS:  w_shift_nxt = {{(DRW-32){1'b0}}, w_dtmcs};
        IR_DMI:    w_shift_nxt = {r_last_addr, r_resp_data, w_op_field};
        default:   w_shift_nxt = {DRW{1'b0}};
      endcase
    end else if (r_state == SH_DR) begin
      case (r_ir)
        IR_IDCODE: w_shift_nxt = {{(DRW-32){1'b0}}, TDI, r_shift[31:1]};
        IR_DTMCS:  w_shift_nxt = {{(DRW-32){1'b0}}, TDI, r_shift[31:1]};
        IR_DMI:    w_shift_nxt = {TDI, r_shift[DRW-1:1]};
        default:   w_shift_nxt = {{(DRW-1){1'b0}}, TDI};
      endcase
    end else begin
      w_shift_nxt = r_shift;
    end
  end

  // Shift register and instruction register
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_shift <= {DRW{1'b0}};
      r_ir    <= IR_IDCODE;
    end else begin
      r_shift <= w_shift_nxt;
      if (r_state == TLR) begin
        r_ir <= IR_IDCODE;
      end else if (r_state == UPD_IR) begin
        r_ir <= r_shift[4:0];
      end
    end
  end

  // TDO launches on the falling edge so the host samples it cleanly on the next rising edge
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      r_tdo <= 1'b0;
    end else begin
      r_tdo <= ((r_state == SH_DR) || (r_state == SH_IR)) ? r_shift[0] : 1'b0;
    end
  end

  // DMI request/response handshake; request fields only load on issue, so they hold while valid
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_req_valid <= 1'b0;
      r_req_addr  <= {ABITS{1'b0}};
      r_req_data  <= 32'h0;
      r_req_op    <= 2'd0;
      r_pending   <= 1'b0;
      r_resp_data <= 32'h0;
      r_last_addr <= {ABITS{1'b0}};
    end else if (w_hardreset_req) begin
      r_req_valid <= 1'b0;
      r_pending   <= 1'b0;
    end else if (w_issue) begin
      r_req_valid <= 1'b1;
      r_req_addr  <= w_dmi_addr;
      r_req_data  <= w_dmi_data;
      r_req_op    <= w_dmi_op;
      r_pending   <= 1'b1;
      r_last_addr <= w_dmi_addr;
    end else begin
      if (r_req_valid && dmi_req_ready) begin
        r_req_valid <= 1'b0;
      end
      if (w_resp_acc) begin
        r_pending   <= 1'b0;
        r_resp_data <= dmi_resp_data;
      end
    end
  end

  // Sticky DMI status: dmireset wins, then busy on access while pending, then first error response
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_dmistat <= 2'd0;
    end else if (w_dmireset) begin
      r_dmistat <= 2'd0;
    end else if ((w_dmi_cap || w_dmi_upd) && r_pending) begin
      r_dmistat <= 2'd3;
    end else if (w_resp_acc && (r_dmistat == 2'd0) &&
                 ((dmi_resp_op == 2'd2) || (dmi_resp_op == 2'd3))) begin
      r_dmistat <= dmi_resp_op;
    end
  end

`ifdef DTM_DMIHARDRESET_EN
  logic r_hardreset;

  // One-cycle debug-module reset pulse
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_hardreset <= 1'b0;
    end else begin
      r_hardreset <= w_hardreset_req;
    end
  end

  assign dmi_hardreset = r_hardreset;
`else
  assign dmi_hardreset = 1'b0;
`endif

endmodule

// File: tb/tb_dtm_tap_dmi.sv
// Directed bench for dtm_tap_dmi: table of register scans plus hand-written DMI handshake sequences.
module tb_dtm_tap_dmi;

  localparam int DW = 41;

  logic        TCK;
  logic        TRST;
  logic        TMS;
  logic        TDI;
  logic        TDO;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready;
  logic [31:0] dmi_resp_data;
  logic [1:0]  dmi_resp_op;
  logic        dmi_hardreset;

  int total;
  int bad;
  int req_count;
  int hr_count;
  logic [6:0]  mon_addr;
  logic [31:0] mon_data;
  logic [1:0]  mon_op;

  dtm_tap_dmi dut (
    .TCK            (TCK),
    .TRST           (TRST),
    .TMS            (TMS),
    .TDI            (TDI),
    .TDO            (TDO),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_data   (dmi_req_data),
    .dmi_req_op     (dmi_req_op),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_ready (dmi_resp_ready),
    .dmi_resp_data  (dmi_resp_data),
    .dmi_resp_op    (dmi_resp_op),
    .dmi_hardreset  (dmi_hardreset)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  always @(posedge TCK) begin
    if (dmi_req_valid && dmi_req_ready) begin
      req_count <= req_count + 1;
      mon_addr  <= dmi_req_addr;
      mon_data  <= dmi_req_data;
      mon_op    <= dmi_req_op;
    end
  end

  always @(negedge TCK) begin
    if (dmi_hardreset) hr_count <= hr_count + 1;
  end

  typedef struct {
    string       name;
    logic [4:0]  ir;
    int          len;
    logic [65:0] din;
    logic [65:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one TCK cycle; returns 7 time units after the rising edge (after TDO has launched)
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #7;
  endtask

  task automatic shift_ir(input logic [4:0] val, output logic [4:0] cap);
    logic [4:0] d;
    d = val;
    cap = 5'd0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (TDO) cap = cap | (5'd1 << i);
      tick((i == 4), d[0]);
      d = d >> 1;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic shift_dr(input int len, input logic [65:0] val, output logic [65:0] cap);
    logic [65:0] d;
    d = val;
    cap = 66'd0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (TDO) cap = cap | (66'd1 << i);
      tick((i == len - 1), d[0]);
      d = d >> 1;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic respond(input logic [1:0] op, input logic [31:0] data);
    dmi_resp_valid = 1'b1;
    dmi_resp_op    = op;
    dmi_resp_data  = data;
    tick(1'b0, 1'b0);
    dmi_resp_valid = 1'b0;
  endtask

  initial begin
    logic [65:0] cap;
    logic [4:0]  irc;
    int          hr_before;

    total = 0;
    bad = 0;
    req_count = 0;
    hr_count = 0;
    TRST = 1'b0;
    TMS = 1'b1;
    TDI = 1'b0;
    dmi_req_ready = 1'b1;
    dmi_resp_valid = 1'b0;
    dmi_resp_data = 32'h0;
    dmi_resp_op = 2'd0;

    vecs[0] = '{name:"idcode32",  ir:5'h01, len:32, din:66'h0,  exp:66'h0000_0001};
    vecs[1] = '{name:"idcode40",  ir:5'h01, len:40, din:66'hFF, exp:66'hFF_0000_0001};
    vecs[2] = '{name:"dtmcs",     ir:5'h10, len:32, din:66'h0,  exp:66'h0000_1071};
    vecs[3] = '{name:"bypass1f",  ir:5'h1F, len:4,  din:66'hB,  exp:66'h6};
    vecs[4] = '{name:"bypass05",  ir:5'h05, len:3,  din:66'h2,  exp:66'h4};
    vecs[5] = '{name:"dmi_idle",  ir:5'h11, len:DW, din:66'h0,  exp:66'h0};

    #1 TRST = 1'b1;
    #1;
    check("rst_tdo", 66'(TDO), 66'd0);
    check("rst_req_valid", 66'(dmi_req_valid), 66'd0);
    check("rst_resp_ready", 66'(dmi_resp_ready), 66'd0);
    check("rst_hardreset", 66'(dmi_hardreset), 66'd0);
    #20;
    TRST = 1'b0;
    tick(1'b0, 1'b0);

    shift_dr(32, 66'd0, cap);
    check("idcode_default_ir", cap, 66'h0000_0001);

    for (int i = 0; i < 6; i++) begin
      shift_ir(vecs[i].ir, irc);
      check("ir_capture", 66'(irc), 66'h01);
      shift_dr(vecs[i].len, vecs[i].din, cap);
      check(vecs[i].name, cap, vecs[i].exp);
    end

    // write request accepted on its first cycle, ok response
    shift_dr(DW, 66'({7'h10, 32'hA5A5_0001, 2'd2}), cap);
    check("wr_cap", cap, 66'd0);
    check("wr_valid", 66'(dmi_req_valid), 66'd1);
    check("wr_fields", 66'({dmi_req_addr, dmi_req_data, dmi_req_op}), 66'({7'h10, 32'hA5A5_0001, 2'd2}));
    tick(1'b0, 1'b0);
    check("wr_valid_drop", 66'(dmi_req_valid), 66'd0);
    check("wr_resp_ready", 66'(dmi_resp_ready), 66'd1);
    check("wr_count", 66'(req_count), 66'd1);
    check("wr_mon", 66'({mon_addr, mon_data, mon_op}), 66'({7'h10, 32'hA5A5_0001, 2'd2}));
    respond(2'd0, 32'hDEAD_BEEF);
    check("wr_resp_ready_low", 66'(dmi_resp_ready), 66'd0);
    shift_dr(DW, 66'd0, cap);
    check("wr_result", cap, 66'({7'h10, 32'hDEAD_BEEF, 2'd0}));

    // busy: rescan while the read is outstanding
    shift_dr(DW, 66'({7'h22, 32'h0, 2'd1}), cap);
    tick(1'b0, 1'b0);
    check("rd_count", 66'(req_count), 66'd2);
    check("rd_mon", 66'({mon_addr, mon_op}), 66'({7'h22, 2'd1}));
    shift_dr(DW, 66'({7'h33, 32'h1111_2222, 2'd2}), cap);
    check("busy_cap", cap, 66'({7'h22, 32'hDEAD_BEEF, 2'd3}));
    tick(1'b0, 1'b0);
    check("busy_suppressed", 66'(req_count), 66'd2);
    check("busy_no_valid", 66'(dmi_req_valid), 66'd0);
    respond(2'd0, 32'h1234_5678);
    shift_ir(5'h10, irc);
    shift_dr(32, 66'h1_0000, cap);
    check("dtmcs_busy", cap, 66'h0000_1C71);
    shift_dr(32, 66'h0, cap);
    check("dtmcs_cleared", cap, 66'h0000_1071);
    shift_ir(5'h11, irc);
    shift_dr(DW, 66'({7'h44, 32'h0, 2'd1}), cap);
    check("rd2_cap", cap, 66'({7'h22, 32'h1234_5678, 2'd0}));
    tick(1'b0, 1'b0);
    check("rd2_count", 66'(req_count), 66'd3);
    check("rd2_addr", 66'(mon_addr), 66'h44);

    // failed response makes dmistat sticky until dmireset
    respond(2'd2, 32'hBAD0_0002);
    shift_dr(DW, 66'({7'h55, 32'hABCD, 2'd2}), cap);
    check("err_cap", cap, 66'({7'h44, 32'hBAD0_0002, 2'd2}));
    tick(1'b0, 1'b0);
    check("err_no_issue", 66'(req_count), 66'd3);
    shift_dr(DW, 66'd0, cap);
    check("err_sticky", cap, 66'({7'h44, 32'hBAD0_0002, 2'd2}));
    shift_ir(5'h10, irc);
    shift_dr(32, 66'h1_0000, cap);
    check("dtmcs_err", cap, 66'h0000_1871);
    shift_ir(5'h11, irc);
    shift_dr(DW, 66'({7'h66, 32'h0F0F, 2'd2}), cap);
    check("post_reset_cap", cap, 66'({7'h44, 32'hBAD0_0002, 2'd0}));
    tick(1'b0, 1'b0);
    check("post_reset_issue", 66'(req_count), 66'd4);
    check("post_reset_data", 66'(mon_data), 66'h0F0F);
    respond(2'd0, 32'h0);

    // dmihardreset with a read outstanding
    shift_dr(DW, 66'({7'h77, 32'h0, 2'd1}), cap);
    tick(1'b0, 1'b0);
    check("hr_pending", 66'(dmi_resp_ready), 66'd1);
    hr_before = hr_count;
    shift_ir(5'h10, irc);
    shift_dr(32, 66'h2_0000, cap);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
`ifdef DTM_DMIHARDRESET_EN
    check("hr_pulse", 66'(hr_count - hr_before), 66'd1);
    check("hr_pending_cleared", 66'(dmi_resp_ready), 66'd0);
`else
    check("hr_no_pulse", 66'(hr_count - hr_before), 66'd0);
    check("hr_pending_kept", 66'(dmi_resp_ready), 66'd1);
`endif
    respond(2'd0, 32'h0);

    // TRST abandons a request that is never accepted
    dmi_req_ready = 1'b0;
    shift_ir(5'h11, irc);
    shift_dr(DW, 66'({7'h5A, 32'hCAFE_F00D, 2'd2}), cap);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("hold_valid", 66'(dmi_req_valid), 66'd1);
    check("hold_fields", 66'({dmi_req_addr, dmi_req_data, dmi_req_op}), 66'({7'h5A, 32'hCAFE_F00D, 2'd2}));
    check("hold_resp_ready", 66'(dmi_resp_ready), 66'd0);
    TRST = 1'b1;
    #1;
    check("trst_valid", 66'(dmi_req_valid), 66'd0);
    check("trst_resp_ready", 66'(dmi_resp_ready), 66'd0);
    check("trst_tdo", 66'(TDO), 66'd0);
    @(posedge TCK);
    #7;
    TRST = 1'b0;
    dmi_req_ready = 1'b1;
    tick(1'b0, 1'b0);
    check("trst_count", 66'(req_count), 66'd5);
    shift_dr(32, 66'd0, cap);
    check("trst_ir_idcode", cap, 66'h0000_0001);
    shift_ir(5'h11, irc);
    shift_dr(DW, 66'd0, cap);
    check("trst_dmi_cleared", cap, 66'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
